// File: rtl/exec_sequencer_if.sv
// Handshake and gating bundle between the harness/Ctrl side and the run sequencer.
// The master drives the request and decoded controls; the slave returns gates, status and counters.
interface exec_sequencer_if #(
   parameter int PC_W  = 10,
   parameter int CNT_W = 16
);
   logic             Req;
   logic             DecAck;
   logic             DecLoad;
   logic             DecRegWrEn;
   logic             DecMemWrEn;
   logic             PcInit;
   logic [PC_W-1:0]  PcStartAddr;
   logic             PcEn;
   logic             RegWrEn;
   logic             MemWrEn;
   logic             Busy;
   logic             Done;
   logic             Timeout;
   logic [CNT_W-1:0] CycleCount;
   logic [CNT_W-1:0] InstCount;

   modport master (
      output Req, DecAck, DecLoad, DecRegWrEn, DecMemWrEn,
      input  PcInit, PcStartAddr, PcEn, RegWrEn, MemWrEn,
      input  Busy, Done, Timeout, CycleCount, InstCount
   );

   modport slave (
      input  Req, DecAck, DecLoad, DecRegWrEn, DecMemWrEn,
      output PcInit, PcStartAddr, PcEn, RegWrEn, MemWrEn,
      output Busy, Done, Timeout, CycleCount, InstCount
   );
endinterface

// File: rtl/exec_sequencer.sv
// Run controller for the 9-bit processor: start/done handshake, PC init, per-cycle gating of
// PC advance and architectural writes, load wait states, watchdog and performance counters.
module exec_sequencer #(
   parameter int          PC_W       = 10,
   parameter int          START_ADDR = 0,
   parameter int          LOAD_LAT   = 1,
   parameter int          CNT_W      = 16,
   parameter int unsigned MAX_CYCLES = 16'hFFF0
) (
   input logic             Clk,
   input logic             Reset,
   exec_sequencer_if.slave bus
);

   typedef enum logic [2:0] {IDLE, INIT, RUN, LWAIT, DONE} state_t;

   localparam bit               HAS_WAIT  = (LOAD_LAT > 0);
   localparam int               WAIT_INIT = HAS_WAIT ? LOAD_LAT - 1 : 0;
   localparam logic [CNT_W-1:0] WD_LAST   = CNT_W'(MAX_CYCLES - 1);

   state_t           state;
   state_t           nxt;
   logic [1:0]       wcnt;
   logic [CNT_W-1:0] cyc;
   logic [CNT_W-1:0] inst;
   logic             tmo;

   logic             pcen;
   logic             rwr;
   logic             mwr;
   logic             retire;
   logic             wload;
   logic             wdec;
   logic             wd;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Watchdog fires on the last permitted run cycle; that cycle still executes normally.
   assign wd = (cyc == WD_LAST);

   always_comb begin
      nxt    = state;
      pcen   = 1'b0;
      rwr    = 1'b0;
      mwr    = 1'b0;
      retire = 1'b0;
      wload  = 1'b0;
      wdec   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.Req) nxt = INIT;
         end
         INIT: begin
            nxt = RUN;
         end
         RUN: begin
            if (bus.DecAck) begin
               retire = 1'b1;
               nxt    = DONE;
            end else if (bus.DecLoad && HAS_WAIT) begin
               wload = 1'b1;
               nxt   = LWAIT;
            end else begin
               pcen   = 1'b1;
               rwr    = bus.DecRegWrEn;
               mwr    = bus.DecMemWrEn && !bus.DecLoad;
               retire = 1'b1;
            end
            if (wd) nxt = DONE;
         end
         LWAIT: begin
            // An expiring watchdog lets the pending load complete rather than dropping it.
            if (wcnt == 2'd0 || wd) begin
               pcen   = 1'b1;
               rwr    = 1'b1;
               retire = 1'b1;
               nxt    = wd ? DONE : RUN;
            end else begin
               wdec = 1'b1;
            end
         end
         DONE: begin
            if (!bus.Req) nxt = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
         wcnt  <= 2'd0;
         cyc   <= '0;
         inst  <= '0;
         tmo   <= 1'b0;
      end else begin
         state <= nxt;
         if (wload) begin
            wcnt <= 2'(WAIT_INIT);
         end else if (wdec) begin
            wcnt <= wcnt - 2'd1;
         end
         case (state)
            INIT: begin
               cyc  <= '0;
               inst <= '0;
               tmo  <= 1'b0;
            end
            RUN, LWAIT: begin
               cyc <= sat_inc(cyc);
               if (retire) inst <= sat_inc(inst);
               if (wd) tmo <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.PcInit      = (state == INIT);
   assign bus.PcStartAddr = PC_W'(START_ADDR);
   assign bus.PcEn        = pcen;
   assign bus.RegWrEn     = rwr;
   assign bus.MemWrEn     = mwr;
   assign bus.Busy        = (state == INIT) || (state == RUN) || (state == LWAIT);
   assign bus.Done        = (state == DONE);
   assign bus.Timeout     = tmo;
   assign bus.CycleCount  = cyc;
   assign bus.InstCount   = inst;

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
- Top-level run controller for the 9-bit processor; sits between the control decoder (Ctrl) and the program counter, register file and data memory write enables.
- Owns the start/done handshake. Initialises the PC, then gates PC advance and all architectural writes cycle by cycle.
- Inserts wait states for data-memory loads, stops on the Ack instruction, and enforces a cycle-budget watchdog.
- Keeps cycle and retired-instruction counters for benchmarking.

Parameters:
- PC_W, 10, program counter width
- START_ADDR, 0, PC value loaded at program start
- LOAD_LAT, 1, extra wait cycles a load needs for memory data (0..3)
- CNT_W, 16, width of the performance counters
- MAX_CYCLES, 16'hFFF0, watchdog limit in run cycles

Ports:
- Clk, in, 1, system clock; all state updates on rising edge
- Reset, in, 1, asynchronous active-high reset
- Req, in, 1, start request from the test harness (level)
- DecAck, in, 1, Ctrl Ack: current instruction is the halt encoding
- DecLoad, in, 1, Ctrl LoadInst
- DecRegWrEn, in, 1, Ctrl RegWrEn
- DecMemWrEn, in, 1, Ctrl MemWrEn
- PcInit, out, 1, load START_ADDR into the PC this edge
- PcStartAddr, out, PC_W, constant START_ADDR
- PcEn, out, 1, PC may advance or branch this edge
- RegWrEn, out, 1, gated register-file write enable
- MemWrEn, out, 1, gated data-memory write enable
- Busy, out, 1, program executing (INIT/RUN/LWAIT)
- Done, out, 1, program finished (Ack to harness)
- Timeout, out, 1, finish was caused by the watchdog
- CycleCount, out, CNT_W, cycles spent in RUN and LWAIT
- InstCount, out, CNT_W, instructions retired, including the halt

Behaviour:
- Reset asserted (any time, including mid-run): state=IDLE. All outputs 0 except PcStartAddr; counters 0.
- States: IDLE, INIT, RUN, LWAIT, DONE. Outputs are combinational from state and Dec* inputs; counters and Timeout are registered.
- IDLE:
  - All gates 0.
  - Req=1 → INIT.
- INIT (exactly 1 cycle):
  - PcInit=1, Busy=1, PcEn=0, no writes.
  - CycleCount, InstCount and Timeout cleared.
  - Next state RUN.
- RUN (instruction from ROM is valid every cycle). Rules in priority order:
  1. Watchdog: CycleCount==MAX_CYCLES-1 → this cycle behaves as a normal instruction, then DONE with Timeout=1 set on the same edge.
  2. DecAck=1 → PcEn=0, RegWrEn=0, MemWrEn=0; InstCount+1; next state DONE.
  3. DecLoad=1 and LOAD_LAT>0 → PcEn=0, RegWrEn=0; wait counter loaded with LOAD_LAT-1; next state LWAIT.
  4. Otherwise: PcEn=1, RegWrEn=DecRegWrEn, MemWrEn=DecMemWrEn; InstCount+1.
  - With LOAD_LAT=0, a load retires in 1 cycle under rule 4.
- LWAIT:
  - The instruction is held stable because the PC is frozen.
  - While wait counter>0: all gates 0; counter decrements.
  - Counter==0: RegWrEn=1, PcEn=1, InstCount+1; next state RUN.
  - The watchdog is also checked here. On expiry the load completes this cycle, then DONE with Timeout=1.
- CycleCount increments every cycle in RUN and LWAIT and saturates at all-ones. InstCount also saturates.
- DONE:
  - Done=1, Busy=0, all gates 0; counters and Timeout hold.
  - Req=0 → IDLE. Done therefore stays high until Req drops.
  - A new program requires Req to be seen low, then high again.
- Req deasserting during INIT/RUN/LWAIT is ignored; the program runs to Ack or the watchdog.
- DecMemWrEn and DecLoad are never both 1, because their decodes are exclusive. If both are 1, load handling wins and MemWrEn=0.

Test Plan:
- Reset mid-LWAIT, then release → all outputs 0, state IDLE. Req=1 → PcInit=1 for exactly 1 cycle, then PcEn=1.
- 3 ALU ops then Ack (DecAck=1 on the 4th RUN cycle) → PcEn high for 3 cycles. Done=1 on the next cycle; CycleCount=4, InstCount=4, Timeout=0, RegWrEn low on the Ack cycle.
- LOAD_LAT=2, single load (DecLoad=1, DecRegWrEn=1) → PcEn and RegWrEn 0 for 2 cycles, 1 on the 3rd; InstCount+1, CycleCount+3.
- Store in RUN (DecMemWrEn=1) → MemWrEn=1 in that cycle only. Same input during DONE or IDLE → MemWrEn=0.
- MAX_CYCLES=8, no Ack → 8 RUN cycles, then Done=1, Timeout=1, CycleCount=8.
- Done reached with Req held 1 → stays in DONE. Req=0 → IDLE. Req=1 → INIT, counters cleared to 0.
